onehot_seq_decoder: RTL and testbench
=====================================

# onehot_seq_decoder

Sequential binary-to-one-hot decoder, the inverse of the team's one-hot encoders. It accepts a binary code and a hold length through a valid/ready handshake. It then drives the matching one-hot line on a registered output for a programmable number of cycles before releasing it. It sits between the control sequencer and downstream one-hot select/enable fabrics such as mux selects and bank enables.

## Interface
- IN_W, 3, width of binary code.
- OUT_W, 8, number of one-hot outputs; legal range 2..2**IN_W.
- HOLD_W, 4, width of hold-length field.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  command valid.
- in_ready  output  1  command can be accepted this cycle.
- in_code  input  IN_W  binary index to decode.
- in_hold  input  HOLD_W  extra hold cycles; line is driven in_hold+1 cycles.
- err_clr  input  1  clears sticky err (only with range check).
- Y  output  OUT_W  registered one-hot output, all-zero when idle.
- out_active  output  1  high whenever a command is being driven.
- done  output  1  one-cycle pulse after a command's last drive cycle.
- err  output  1  sticky out-of-range flag (only with range check, else tied 0).

Clock and reset are `clk`, with one clock domain. Reset `rst_n` is asynchronous and active-low.

## Operation
- FSM states are IDLE and DRIVE.
- Accept means in_valid && in_ready.
- in_ready = (state==IDLE) || (state==DRIVE && cnt==0). It is combinational from registered state and is forced 0 while rst_n is low.
- IDLE, on accept:
  - Y <= 1<<in_code.
  - cnt <= in_hold.
  - out_active <= 1.
  - Go to DRIVE.
- IDLE, with no accept: Y stays 0.
- DRIVE with cnt!=0: cnt decrements and Y holds.
- DRIVE with cnt==0 and accept (back-to-back): Y switches directly to the new one-hot code, cnt reloads, state stays DRIVE, and done pulses next cycle. There is no zero gap on Y.
- DRIVE with cnt==0 and no accept: Y <= 0, out_active <= 0, go to IDLE, and done pulses next cycle.
- in_code, in_hold and in_valid are sampled only on accept. Changes while not ready are ignored.
- Y is always a zero or one-hot vector. Exactly one bit is set while out_active is high, except for suppressed out-of-range codes (see Configuration).
- in_hold = 0 gives exactly one drive cycle. in_hold = 2**HOLD_W-1 gives 2**HOLD_W cycles. The counter never wraps because it is only decremented when nonzero.

## Timing
- Reset values: Y=0, out_active=0, done=0, err=0, state=IDLE, cnt=0.
- Reset asserted mid-command clears everything immediately (asynchronously). No done pulse is emitted for the aborted command.
- Latency: Y changes in the cycle after accept. For an accept at edge k, Y is valid from edge k+1 through edge k+1+in_hold.
- done is registered. It is high for exactly one cycle, starting at the edge where Y leaves the finished code.
- Throughput: one command per in_hold+1 cycles with no bubbles when in_valid is held high.

## Configuration
- ONEHOT_RANGE_CHK_EN defined:
  - A code with in_code >= OUT_W is still accepted and timed normally (out_active, cnt, done behave as usual), but Y stays all-zero for its duration.
  - err is set the cycle after accept and stays set until err_clr.
  - If err_clr and a new error occur in the same cycle, set wins.
- ONEHOT_RANGE_CHK_EN undefined:
  - err is tied to 0 and err_clr is ignored.
  - An out-of-range code yields Y = (1<<in_code) truncated to OUT_W bits, i.e. all-zero, with identical timing.
  - There is no checking logic.

## Structure
- Package onehot_pkg holds:
  - the state enum (IDLE, DRIVE);
  - the clog2-style width helper;
  - the default width constants shared with the encoders.
- Sub-module onehot_hold_cnt is the HOLD_W-bit load/decrement counter, with a zero flag and load-priority-over-decrement. The top contains the FSM, the decode register and done/err.

## Test plan
- Reset then single command: code=5, hold=2 -> Y=8'b0010_0000 for 3 cycles starting one cycle after accept. done pulses once as Y returns to 0. in_ready is low during the first 2 drive cycles.
- Back-to-back: code=0 hold=0, then code=7 hold=1 with in_valid held high -> Y=01h for 1 cycle, then 80h for 2 cycles, then 00h. There is no zero cycle between codes, and done pulses twice.
- Hold extremes: hold=0 -> 1 cycle. hold=15 (HOLD_W=4) -> exactly 16 cycles with no wrap. in_valid toggling while busy is ignored.
- Reset mid-operation: rst_n pulled low during cycle 2 of code=3 hold=5 -> Y=0 and out_active=0 immediately. No done pulse. in_ready goes to 1 after release.
- Range check (OUT_W=6, ONEHOT_RANGE_CHK_EN): code=6 hold=1 -> Y=0 for 2 cycles, out_active=1, err sets and stays. err_clr clears it. A simultaneous clear and new error leaves err=1.
- Exhaustive: all codes 0..OUT_W-1 with random holds -> Y == 1<<code and $onehot(Y) holds whenever out_active is high. Y == 0 whenever out_active is low.

Source files
------------

// File: rtl/onehot_seq_decoder_pkg.sv
// Shared types and width constants for the one-hot encoder/decoder family.
package onehot_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        DRIVE = 1'b1
    } state_e;

    // Bits needed to index n items (minimum 1).
    function automatic int clog2w(input int n);
        int w;
        w = 1;
        while ((1 << w) < n) w++;
        return w;
    endfunction

    localparam int DEF_OUT_W  = 8;
    localparam int DEF_IN_W   = clog2w(DEF_OUT_W);
    localparam int DEF_HOLD_W = 4;

endpackage

// File: rtl/onehot_seq_decoder_if.sv
// Command/output bundle for onehot_seq_decoder.
// Handshake: a command transfers on a rising edge where in_valid && in_ready;
// in_code/in_hold are sampled only then, and the master may change them freely otherwise.
interface onehot_seq_decoder_if #(
    parameter int IN_W   = 3,
    parameter int OUT_W  = 8,
    parameter int HOLD_W = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [IN_W-1:0]   in_code;
    logic [HOLD_W-1:0] in_hold;
    logic              err_clr;
    logic [OUT_W-1:0]  Y;
    logic              out_active;
    logic              done;
    logic              err;

    modport master (
        output in_valid, in_code, in_hold, err_clr,
        input  in_ready, Y, out_active, done, err
    );

    modport slave (
        input  in_valid, in_code, in_hold, err_clr,
        output in_ready, Y, out_active, done, err
    );
endinterface

// File: rtl/onehot_seq_decoder_hold_cnt.sv
// Hold-length counter: load has priority over decrement; never decrements below zero.
module onehot_hold_cnt #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic [W-1:0] cnt_o,
    output logic         zero_o
);
    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i)
            cnt_d = load_val_i;
        else if (dec_i && (cnt_q != '0))
            cnt_d = cnt_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign cnt_o  = cnt_q;
    assign zero_o = (cnt_q == '0);
endmodule

// File: rtl/onehot_seq_decoder.sv
// Sequential binary-to-one-hot decoder: drives line in_code for in_hold+1 cycles.
// Optional out-of-range checking with sticky err is enabled by ONEHOT_RANGE_CHK_EN.
module onehot_seq_decoder
    import onehot_pkg::*;
#(
    parameter int IN_W   = DEF_IN_W,
    parameter int OUT_W  = DEF_OUT_W,
    parameter int HOLD_W = DEF_HOLD_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    onehot_seq_decoder_if.slave     bus,
    output state_e                  dbg_state_o
);
    state_e            state_q, state_d;
    logic [OUT_W-1:0]  y_q, y_d;
    logic              active_q, active_d;
    logic              done_q, done_d;
    logic              cnt_load, cnt_dec, cnt_zero;
    logic [HOLD_W-1:0] cnt;
    logic              accept;
    logic [OUT_W-1:0]  y_dec;
    logic [(1<<IN_W)-1:0] full_dec;

    onehot_hold_cnt #(.W(HOLD_W)) u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (bus.in_hold),
        .dec_i      (cnt_dec),
        .cnt_o      (cnt),
        .zero_o     (cnt_zero)
    );

    // Counter is zero in IDLE too, so ready reduces to "counter exhausted".
    assign bus.in_ready = rst_n && ((state_q == IDLE) || cnt_zero);
    assign accept       = bus.in_valid && bus.in_ready;

`ifdef ONEHOT_RANGE_CHK_EN
    localparam logic [IN_W:0] OUT_W_L = (IN_W+1)'(OUT_W);
    logic oor;
    logic err_q, err_d;
    assign oor = ({1'b0, bus.in_code} >= OUT_W_L);

    always_comb begin
        full_dec = '0;
        full_dec[bus.in_code] = 1'b1;
        y_dec = oor ? '0 : full_dec[OUT_W-1:0];
    end

    // A new error wins over a simultaneous clear.
    always_comb begin
        err_d = err_q;
        if (accept && oor)    err_d = 1'b1;
        else if (bus.err_clr) err_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign bus.err = err_q;
`else
    logic unused_err_clr;
    assign unused_err_clr = bus.err_clr;

    always_comb begin
        full_dec = '0;
        full_dec[bus.in_code] = 1'b1;
        y_dec = full_dec[OUT_W-1:0];
    end

    assign bus.err = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        y_d      = y_q;
        active_d = active_q;
        done_d   = 1'b0;
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    y_d      = y_dec;
                    cnt_load = 1'b1;
                    active_d = 1'b1;
                    state_d  = DRIVE;
                end
            end
            DRIVE: begin
                if (!cnt_zero) begin
                    cnt_dec = 1'b1;
                end else if (accept) begin
                    y_d      = y_dec;
                    cnt_load = 1'b1;
                    done_d   = 1'b1;
                end else begin
                    y_d      = '0;
                    active_d = 1'b0;
                    done_d   = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            y_q      <= '0;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            y_q      <= y_d;
            active_q <= active_d;
            done_q   <= done_d;
        end
    end

    assign bus.Y          = y_q;
    assign bus.out_active = active_q;
    assign bus.done       = done_q;
    assign dbg_state_o    = state_q;
endmodule

// File: tb/tb_onehot_seq_decoder.sv
// Self-checking bench for onehot_seq_decoder (default build and ONEHOT_RANGE_CHK_EN).
module tb_onehot_seq_decoder;
  import onehot_pkg::*;

  localparam int IN_W   = 3;
`ifdef ONEHOT_RANGE_CHK_EN
  localparam int OUT_W  = 6;
`else
  localparam int OUT_W  = 8;
`endif
  localparam int HOLD_W = 4;

  typedef struct {
    logic [IN_W-1:0]   code;
    logic [HOLD_W-1:0] hold;
    logic [OUT_W-1:0]  exp_y;
    logic              exp_err;
  } vec_t;

  logic   clk;
  logic   rst_n;
  state_e dbg_state;

  onehot_seq_decoder_if #(.IN_W(IN_W), .OUT_W(OUT_W), .HOLD_W(HOLD_W)) bus ();

  onehot_seq_decoder #(.IN_W(IN_W), .OUT_W(OUT_W), .HOLD_W(HOLD_W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int act_cycles = 0;
  logic mon_en = 1'b0;
  logic [OUT_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [OUT_W-1:0] model_y(input int c);
    logic [OUT_W-1:0] one;
    one = 1;
    return (c < OUT_W) ? (one << c) : '0;
  endfunction

  // scoreboard monitor
  always @(negedge clk) begin
    if (rst_n && mon_en) begin
      if (bus.done) done_cnt++;
      if (bus.out_active) begin
        act_cycles++;
        if (exp_q.size() == 0) begin
          check("unexpected_drive", 32'(bus.Y), 32'hdead);
        end else begin
          logic [OUT_W-1:0] e;
          e = exp_q.pop_front();
          check("y_drive", 32'(bus.Y), 32'(e));
          if (e != '0) check("y_onehot", 32'($onehot(bus.Y)), 32'd1);
        end
      end else begin
        check("y_idle_zero", 32'(bus.Y), 32'd0);
      end
    end
  end

  // driver tasks: called from a negedge, return at the negedge after accept
  task automatic issue(input logic [IN_W-1:0] c, input logic [HOLD_W-1:0] h);
    int t;
    bus.in_valid = 1'b1;
    bus.in_code  = c;
    bus.in_hold  = h;
    t = 0;
    while (!bus.in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (t >= 100) check("ready_timeout", 32'(t), 32'd0);
    @(posedge clk);
    for (int i = 0; i <= int'(h); i++) exp_q.push_back(model_y(int'(c)));
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while (bus.out_active && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) check("idle_timeout", 32'(t), 32'd0);
    @(negedge clk);
  endtask

  vec_t vecs[OUT_W + 4];
  int   nvec;
  logic err_m;

  initial begin
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_code  = '0;
    bus.in_hold  = '0;
    bus.err_clr  = 1'b0;
    err_m        = 1'b0;
    #2;
    check("ready_in_reset", 32'(bus.in_ready), 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_y", 32'(bus.Y), 32'd0);
    check("rst_active", 32'(bus.out_active), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    check("rst_ready", 32'(bus.in_ready), 32'd1);
    check("rst_state", 32'(dbg_state), 32'(IDLE));
    mon_en = 1'b1;

    // single command: code 5, hold 2
    done_cnt = 0; act_cycles = 0;
    issue(3'd5, 4'd2);
    bus.in_valid = 1'b0;
    #1 check("single_ready_c1", 32'(bus.in_ready), 32'd0);
    check("single_y_c1", 32'(bus.Y), 32'h20);
    @(negedge clk); #1 check("single_ready_c2", 32'(bus.in_ready), 32'd0);
    @(negedge clk); #1 check("single_ready_c3", 32'(bus.in_ready), 32'd1);
    @(negedge clk); #1 check("single_done", 32'(bus.done), 32'd1);
    check("single_y_off", 32'(bus.Y), 32'd0);
    @(negedge clk); #1 check("single_done_once", 32'(bus.done), 32'd0);
    check("single_cycles", 32'(act_cycles), 32'd3);
    check("single_done_cnt", 32'(done_cnt), 32'd1);

    // back-to-back: code 0 hold 0 then code 7 hold 1, no zero gap
    @(negedge clk);
    done_cnt = 0;
    issue(3'd0, 4'd0);
    #1 check("b2b_y0", 32'(bus.Y), 32'(model_y(0)));
    issue(3'd7, 4'd1);
    bus.in_valid = 1'b0;
    #1 check("b2b_y1a", 32'(bus.Y), 32'(model_y(7)));
    check("b2b_active_a", 32'(bus.out_active), 32'd1);
    @(negedge clk); #1 check("b2b_y1b", 32'(bus.Y), 32'(model_y(7)));
    @(negedge clk); #1 check("b2b_y_end", 32'(bus.Y), 32'd0);
    @(negedge clk);
    check("b2b_done_cnt", 32'(done_cnt), 32'd2);

    // hold 15 with in_valid toggling while busy
    act_cycles = 0;
    issue(3'd3, 4'd15);
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = i[0];
      bus.in_code  = 3'($urandom_range(0, 7));
      bus.in_hold  = 4'($urandom_range(0, 15));
      @(negedge clk);
    end
    bus.in_valid = 1'b0;
    wait_idle();
    check("hold15_cycles", 32'(act_cycles), 32'd16);

    // hold 0
    act_cycles = 0;
    issue(3'd1, 4'd0);
    bus.in_valid = 1'b0;
    wait_idle();
    check("hold0_cycles", 32'(act_cycles), 32'd1);

    // reset mid-command
    done_cnt = 0;
    issue(3'd3, 4'd5);
    bus.in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_y", 32'(bus.Y), 32'd0);
    check("midrst_active", 32'(bus.out_active), 32'd0);
    check("midrst_ready", 32'(bus.in_ready), 32'd0);
    exp_q.delete();
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("midrst_ready_after", 32'(bus.in_ready), 32'd1);
    repeat (4) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt), 32'd0);

    // table: every code, random holds
    nvec = 0;
    for (int c = 0; c < (1 << IN_W); c++) begin
      if (c < OUT_W || nvec < OUT_W + 2) begin
`ifndef ONEHOT_RANGE_CHK_EN
        if (c >= OUT_W) continue;
`endif
        vecs[nvec].code    = 3'(c);
        vecs[nvec].hold    = 4'($urandom_range(0, 4));
        vecs[nvec].exp_y   = model_y(c);
`ifdef ONEHOT_RANGE_CHK_EN
        err_m = err_m | (c >= OUT_W);
`endif
        vecs[nvec].exp_err = err_m;
        nvec++;
      end
    end
    for (int i = 0; i < nvec; i++) begin
      done_cnt = 0; act_cycles = 0;
      issue(vecs[i].code, vecs[i].hold);
      bus.in_valid = 1'b0;
      #1 check("tbl_y_first", 32'(bus.Y), 32'(vecs[i].exp_y));
      wait_idle();
      check("tbl_cycles", 32'(act_cycles), 32'(int'(vecs[i].hold) + 1));
      check("tbl_done", 32'(done_cnt), 32'd1);
      check("tbl_err", 32'(bus.err), 32'(vecs[i].exp_err));
    end

`ifdef ONEHOT_RANGE_CHK_EN
    // sticky err, clear, and clear colliding with a new error
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    check("err_cleared", 32'(bus.err), 32'd0);
    bus.in_valid = 1'b1;
    bus.in_code  = 3'd6;
    bus.in_hold  = 4'd1;
    bus.err_clr  = 1'b1;
    @(posedge clk);
    exp_q.push_back('0);
    exp_q.push_back('0);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.err_clr  = 1'b0;
    check("err_set_wins", 32'(bus.err), 32'd1);
    check("oor_active", 32'(bus.out_active), 32'd1);
    wait_idle();
    check("err_sticky", 32'(bus.err), 32'd1);
`endif

    repeat (2) @(negedge clk);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  // global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
